// File: rtl/exe_mem_pipe_reg_if.sv
// EXE->MEM stage bundle: handshake, instruction fields, last-store export and store lookup.
// master drives the EXE-side inputs, slave is the pipeline register itself.
interface exe_mem_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] exe_pc;
  logic              exe_we;
  logic [REG_AW-1:0] exe_write_reg;
  logic [DATA_W-1:0] exe_write_data;
  logic [OP_W-1:0]   exe_mem_op;
  logic [DATA_W-1:0] exe_mem_addr;
  logic [DATA_W-1:0] exe_mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] mem_pc;
  logic              mem_we;
  logic [REG_AW-1:0] mem_write_reg;
  logic [DATA_W-1:0] mem_write_data;
  logic [OP_W-1:0]   mem_mem_op;
  logic [DATA_W-1:0] mem_mem_addr;
  logic [DATA_W-1:0] mem_mem_data;
  logic [DATA_W-1:0] last_store_addr;
  logic [DATA_W-1:0] last_store_data;
  logic [DATA_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;

  modport master (
    output flush, in_valid, exe_pc, exe_we, exe_write_reg, exe_write_data, exe_mem_op,
           exe_mem_addr, exe_mem_data, out_ready, lookup_addr,
    input  in_ready, out_valid, mem_pc, mem_we, mem_write_reg, mem_write_data, mem_mem_op,
           mem_mem_addr, mem_mem_data, last_store_addr, last_store_data, lookup_hit, lookup_data
  );

  modport slave (
    input  flush, in_valid, exe_pc, exe_we, exe_write_reg, exe_write_data, exe_mem_op,
           exe_mem_addr, exe_mem_data, out_ready, lookup_addr,
    output in_ready, out_valid, mem_pc, mem_we, mem_write_reg, mem_write_data, mem_mem_op,
           mem_mem_addr, mem_mem_data, last_store_addr, last_store_data, lookup_hit, lookup_data
  );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready, stall, flush and last-store export.
// Define EXE_MEM_SB_EN to build the circular store history with store-to-load lookup.
module exe_mem_pipe_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned NOP_OP   = 0,
  parameter int unsigned SW_OP    = 6,
  parameter int unsigned SB_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  exe_mem_pipe_reg_if.slave bus
);

  localparam logic [OP_W-1:0] NopOp = OP_W'(NOP_OP);
  localparam logic [OP_W-1:0] SwOp  = OP_W'(SW_OP);

  logic              out_valid_q;
  logic [DATA_W-1:0] pc_q;
  logic              we_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q;
  logic [DATA_W-1:0] ls_addr_q;
  logic [DATA_W-1:0] ls_data_q;

  logic accept;
  logic store_en;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign store_en     = accept && !bus.flush && (bus.exe_mem_op == SwOp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      op_q        <= NopOp;
      addr_q      <= '0;
      sdata_q     <= '0;
      ls_addr_q   <= '0;
      ls_data_q   <= '0;
    end else if (bus.flush) begin
      // Held instruction and same-cycle input are both killed.
      out_valid_q <= 1'b0;
      we_q        <= 1'b0;
      op_q        <= NopOp;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= bus.exe_pc;
      we_q        <= bus.exe_we;
      rd_q        <= bus.exe_write_reg;
      wdata_q     <= bus.exe_write_data;
      op_q        <= bus.exe_mem_op;
      addr_q      <= bus.exe_mem_addr;
      sdata_q     <= bus.exe_mem_data;
      if (store_en) begin
        ls_addr_q <= bus.exe_mem_addr;
        ls_data_q <= bus.exe_mem_data;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      we_q        <= 1'b0;
      op_q        <= NopOp;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.mem_pc          = pc_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_write_reg   = rd_q;
  assign bus.mem_write_data  = wdata_q;
  assign bus.mem_mem_op      = op_q;
  assign bus.mem_mem_addr    = addr_q;
  assign bus.mem_mem_data    = sdata_q;
  assign bus.last_store_addr = ls_addr_q;
  assign bus.last_store_data = ls_data_q;

`ifdef EXE_MEM_SB_EN
  localparam int unsigned PtrW  = $clog2(SB_DEPTH);
  localparam int unsigned WordW = DATA_W - 2;

  logic [WordW-1:0]  sb_word_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld_q;
  logic [PtrW-1:0]   wr_ptr_q;

  logic              upd_hit;
  logic [PtrW-1:0]   upd_idx;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;

  // Entries are unique per word, so at most one match per probe.
  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (sb_vld_q[i] && (sb_word_q[i] == bus.exe_mem_addr[DATA_W-1:2])) begin
        upd_hit = 1'b1;
        upd_idx = PtrW'(i);
      end
      if (sb_vld_q[i] && (sb_word_q[i] == bus.lookup_addr[DATA_W-1:2])) begin
        lk_hit  = 1'b1;
        lk_data = sb_data_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_vld_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        sb_word_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else if (store_en) begin
      if (upd_hit) begin
        sb_data_q[upd_idx] <= bus.exe_mem_data;
      end else begin
        sb_word_q[wr_ptr_q] <= bus.exe_mem_addr[DATA_W-1:2];
        sb_data_q[wr_ptr_q] <= bus.exe_mem_data;
        sb_vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
    end
  end

  assign bus.lookup_hit  = lk_hit;
  assign bus.lookup_data = lk_data;

  logic unused_lk_lsb;
  assign unused_lk_lsb = ^bus.lookup_addr[1:0];
`else
  assign bus.lookup_hit  = 1'b0;
  assign bus.lookup_data = '0;

  logic unused_sb;
  assign unused_sb = ^{bus.lookup_addr, 32'(SB_DEPTH)};
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scoreboard bench for exe_mem_pipe_reg; lookup expectations follow EXE_MEM_SB_EN.
module tb_exe_mem_pipe_reg;

  localparam int unsigned DW  = 32;
  localparam int unsigned RAW = 5;
  localparam int unsigned OW  = 4;
  localparam logic [OW-1:0] NOP = 4'd0;
  localparam logic [OW-1:0] SW  = 4'd6;
  localparam logic [OW-1:0] LW  = 4'd2;
`ifdef EXE_MEM_SB_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0]  pc;
    logic           we;
    logic [RAW-1:0] rd;
    logic [DW-1:0]  wd;
    logic [OW-1:0]  op;
    logic [DW-1:0]  addr;
    logic [DW-1:0]  data;
  } item_t;

  logic clk;
  logic rst;
  item_t exp_q[$];
  logic [DW-1:0] exp_ls_addr;
  logic [DW-1:0] exp_ls_data;
  int checks;
  int failures;

  exe_mem_pipe_reg_if #(.DATA_W(DW), .REG_AW(RAW), .OP_W(OW)) ifc ();

  exe_mem_pipe_reg #(
    .DATA_W(DW), .REG_AW(RAW), .OP_W(OW), .NOP_OP(0), .SW_OP(6), .SB_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  function automatic item_t dut_out();
    return {ifc.mem_pc, ifc.mem_we, ifc.mem_write_reg, ifc.mem_write_data, ifc.mem_mem_op,
            ifc.mem_mem_addr, ifc.mem_mem_data};
  endfunction

  task automatic set_in(input logic v, input logic [DW-1:0] pc, input logic we,
                        input logic [RAW-1:0] rd, input logic [DW-1:0] wd,
                        input logic [OW-1:0] op, input logic [DW-1:0] addr,
                        input logic [DW-1:0] data);
    ifc.in_valid       = v;
    ifc.exe_pc         = pc;
    ifc.exe_we         = we;
    ifc.exe_write_reg  = rd;
    ifc.exe_write_data = wd;
    ifc.exe_mem_op     = op;
    ifc.exe_mem_addr   = addr;
    ifc.exe_mem_data   = data;
  endtask

  // Scoreboard update for the coming edge, then advance past it.
  task automatic tick();
    bit acc;
    acc = ifc.in_valid && (exp_q.size() == 0 || ifc.out_ready);
    if (rst) begin
      exp_q.delete();
      exp_ls_addr = '0;
      exp_ls_data = '0;
    end else if (ifc.flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ifc.out_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({ifc.exe_pc, ifc.exe_we, ifc.exe_write_reg, ifc.exe_write_data,
                         ifc.exe_mem_op, ifc.exe_mem_addr, ifc.exe_mem_data});
        if (ifc.exe_mem_op == SW) begin
          exp_ls_addr = ifc.exe_mem_addr;
          exp_ls_data = ifc.exe_mem_data;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] addr,
                       input logic [DW-1:0] data);
    ifc.out_ready = 1'b1;
    set_in(1'b1, 32'h2000, 1'b0, '0, '0, op, addr, data);
    tick();
    ifc.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.flush = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.lookup_addr = '0;
    set_in(1'b0, '0, 1'b0, '0, '0, NOP, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs: got valid=%0b ready=%0b want valid=0 ready=1",
               ifc.out_valid, ifc.in_ready);
    end
    checks++;
    if (dut_out() !== item_t'(0) || ifc.mem_mem_op !== NOP) begin
      failures++;
      $display("FAIL reset_fields: got=%0h want=0", dut_out());
    end
    checks++;
    if ({ifc.last_store_addr, ifc.last_store_data, ifc.lookup_hit} !== '0) begin
      failures++;
      $display("FAIL reset_store: got addr=%0h data=%0h hit=%0b want 0", ifc.last_store_addr,
               ifc.last_store_data, ifc.lookup_hit);
    end
  endtask

  task automatic test_stall();
    ifc.out_ready = 1'b0;
    set_in(1'b1, 32'h40, 1'b1, 5'd3, 32'h1234, LW, 32'h80, '0);
    tick();
    // Offered next instruction must not displace the held one.
    ifc.exe_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q.size() != 1 || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 ||
          ifc.mem_pc !== 32'h40 || dut_out() !== exp_q[0]) begin
        failures++;
        $display("FAIL stall_hold%0d: got valid=%0b ready=%0b pc=%0h want valid=1 ready=0 pc=40",
                 i, ifc.out_valid, ifc.in_ready, ifc.mem_pc);
      end
      if (i < 2) tick();
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.mem_mem_op !== NOP || ifc.mem_we !== 1'b0 ||
        ifc.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain: got valid=%0b op=%0h we=%0b want valid=0 op=0 we=0",
               ifc.out_valid, ifc.mem_mem_op, ifc.mem_we);
    end
  endtask

  task automatic test_back_to_back();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 32'h1000 + 32'(4 * i), 1'(i), 5'(i + 1), $urandom, (i == 3) ? LW : 4'd1,
             $urandom, $urandom);
      tick();
      checks++;
      if (exp_q.size() != 1 || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b1 ||
          ifc.mem_pc !== 32'h1000 + 32'(4 * i) || dut_out() !== exp_q[0]) begin
        failures++;
        $display("FAIL b2b%0d: got valid=%0b fields=%0h want valid=1 fields=%0h", i,
                 ifc.out_valid, dut_out(), (exp_q.size() != 0) ? exp_q[0] : item_t'(0));
      end
    end
    ifc.in_valid = 1'b0;
    tick();
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: got valid=%0b want 0", ifc.out_valid);
    end
  endtask

  task automatic test_store_lookup();
    issue(SW, 32'h100, 32'hAA);
    checks++;
    if (ifc.last_store_addr !== 32'h100 || ifc.last_store_data !== 32'hAA ||
        ifc.last_store_addr !== exp_ls_addr) begin
      failures++;
      $display("FAIL last_store: got %0h/%0h want 100/aa", ifc.last_store_addr,
               ifc.last_store_data);
    end
    ifc.lookup_addr = 32'h102;
    #1;
    checks++;
    if (ifc.lookup_hit !== SbEn || ifc.lookup_data !== (SbEn ? 32'hAA : 32'h0)) begin
      failures++;
      $display("FAIL lookup_102: got hit=%0b data=%0h want hit=%0b", ifc.lookup_hit,
               ifc.lookup_data, SbEn);
    end
    issue(LW, 32'h104, 32'h55);
    ifc.lookup_addr = 32'h104;
    #1;
    checks++;
    if (ifc.lookup_hit !== 1'b0 || ifc.lookup_data !== '0 || ifc.last_store_addr !== 32'h100) begin
      failures++;
      $display("FAIL lookup_104: got hit=%0b data=%0h ls=%0h want hit=0 data=0 ls=100",
               ifc.lookup_hit, ifc.lookup_data, ifc.last_store_addr);
    end
  endtask

  task automatic probe(input string name, input logic [DW-1:0] a, input bit hit,
                       input logic [DW-1:0] d);
    ifc.lookup_addr = a;
    #1;
    checks++;
    if (ifc.lookup_hit !== (hit && SbEn) || ifc.lookup_data !== ((hit && SbEn) ? d : '0)) begin
      failures++;
      $display("FAIL %s: got hit=%0b data=%0h want hit=%0b data=%0h", name, ifc.lookup_hit,
               ifc.lookup_data, hit && SbEn, (hit && SbEn) ? d : '0);
    end
  endtask

  task automatic test_history();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) issue(SW, 32'h200 + 32'(16 * i), 32'h11 * 32'(i + 1));
    probe("hist_evicted", 32'h201, 1'b0, '0);
    for (int i = 1; i < 5; i++) probe("hist_kept", 32'h200 + 32'(16 * i) + 32'(i % 4), 1'b1,
                                      32'h11 * 32'(i + 1));
    issue(SW, 32'h232, 32'h99);
    probe("hist_inplace", 32'h230, 1'b1, 32'h99);
    probe("hist_oldest", 32'h210, 1'b1, 32'h22);
    issue(SW, 32'h250, 32'h66);
    probe("hist_wrap_evict", 32'h210, 1'b0, '0);
    probe("hist_wrap_keep", 32'h220, 1'b1, 32'h33);
    probe("hist_wrap_new", 32'h250, 1'b1, 32'h66);
  endtask

  task automatic test_flush();
    ifc.out_ready = 1'b0;
    ifc.flush = 1'b1;
    set_in(1'b1, 32'h3000, 1'b1, 5'd7, 32'h77, SW, 32'h300, 32'h33);
    tick();
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.mem_we !== 1'b0 || ifc.mem_mem_op !== NOP ||
        ifc.last_store_addr !== 32'h250 || ifc.last_store_data !== 32'h66) begin
      failures++;
      $display("FAIL flush_accept: got valid=%0b we=%0b op=%0h ls=%0h/%0h want 0/0/0 250/66",
               ifc.out_valid, ifc.mem_we, ifc.mem_mem_op, ifc.last_store_addr,
               ifc.last_store_data);
    end
    probe("flush_no_rec", 32'h300, 1'b0, '0);
    set_in(1'b1, 32'h3100, 1'b1, 5'd9, 32'h88, LW, 32'h310, '0);
    tick();
    ifc.in_valid = 1'b0;
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.mem_we !== 1'b0 || ifc.mem_mem_op !== NOP) begin
      failures++;
      $display("FAIL flush_held: got valid=%0b we=%0b op=%0h want 0/0/0", ifc.out_valid,
               ifc.mem_we, ifc.mem_mem_op);
    end
    set_in(1'b1, 32'h4000, 1'b1, 5'd4, 32'h44, SW, 32'h400, 32'h44);
    tick();
    ifc.in_valid = 1'b0;
    tick();
    probe("stall_store", 32'h400, 1'b1, 32'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || dut_out() !== item_t'(0) ||
        {ifc.last_store_addr, ifc.last_store_data} !== {exp_ls_addr, exp_ls_data} ||
        ifc.last_store_addr !== '0) begin
      failures++;
      $display("FAIL rst_stall: got valid=%0b ready=%0b fields=%0h ls=%0h want all 0",
               ifc.out_valid, ifc.in_ready, dut_out(), ifc.last_store_addr);
    end
    probe("rst_hist", 32'h400, 1'b0, '0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_ls_addr = '0;
    exp_ls_data = '0;
    test_reset();
    test_stall();
    test_back_to_back();
    test_store_lookup();
    test_history();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
